sum_accum_beta: RTL
===================

// Module: sum_accum_beta
// PURPOSE
//  Downstream consumer of the 32-bit adder result stream. Accepts sums over valid/ready,
//  accumulates COUNT samples (or fewer on flush) into a wide accumulator and presents
//  the batch total, sample count and overflow flag on a valid/ready output held until taken.
//  Sits between the adder datapath and the result sink; back-pressures the adder side.
// PARAMETERS
//  DATA_W  32  width of each incoming sum
//  ACC_W   40  accumulator / out_sum width (ACC_W >= DATA_W)
//  COUNT   4   samples per batch (COUNT >= 1)
//  CNT_W   derived localparam = $clog2(COUNT+1), not overridable
// PORTS
//  clock      in   1       single clock, all state on posedge
//  reset      in   1       synchronous, active-high
//  in_valid   in   1       in_data valid
//  in_ready   out  1       block can take in_data this cycle
//  in_data    in   DATA_W  unsigned sum from adder stage
//  flush      in   1       close current batch early (level, sampled each cycle)
//  out_valid  out  1       batch result valid
//  out_ready  in   1       sink accepts result
//  out_sum    out  ACC_W   batch total, modulo 2^ACC_W
//  out_count  out  CNT_W   samples in batch, 1..COUNT
//  out_ovf    out  1       accumulator wrapped at least once in this batch
// BEHAVIOUR
//  - Clock and reset: one clock `clock`; reset `reset` is synchronous and active-high.
//  - Reset: state=IDLE; acc=0, cnt=0, ovf=0; out_valid=0, out_sum=0, out_count=0, out_ovf=0.
//    Reset asserted mid-batch or while out_valid=1 discards all data. in_ready=1 on the
//    first cycle after reset deasserts.
//  - Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//    in_ready = !out_valid | out_ready (combinational from out_ready).
//    out_* stay stable while out_valid & !out_ready.
//  - States:
//    IDLE  (cnt=0)
//    ACCUM (0<cnt<COUNT)
//    HOLD  (out_valid=1)
//  - Accumulate on in_fire:
//    {carry, acc_n} = acc + zero-extended in_data (ACC_W+1 bits); cnt_n = cnt+1;
//    ovf_n = ovf | carry.
//    If the batch is in HOLD and out_fire occurs in the same cycle, the new sample starts
//    a fresh batch: acc_n = in_data, cnt_n = 1, ovf_n = 0.
//  - Batch closes when cnt_n == COUNT, or when flush=1 and cnt_n > 0. On close:
//    out_sum <= acc_n, out_count <= cnt_n, out_ovf <= ovf_n, out_valid <= 1;
//    internal acc, cnt, ovf <= 0.
//    Latency: last sample accepted at edge N -> out_valid high after edge N.
//  - Flush with cnt_n == 0 (IDLE, no in_fire) is ignored.
//  - Flush during HOLD without out_fire is ignored; it is not remembered.
//  - COUNT=1: every accepted sample closes its own batch; full throughput when
//    out_ready is held at 1.
//  - HOLD -> IDLE on out_fire with no in_fire.
//    HOLD -> ACCUM (or HOLD again on immediate close) on out_fire & in_fire.
//  - Throughput: one sample per cycle sustained when out_ready=1; no bubble at batch
//    boundaries.
// STRUCTURE
//  - Package sum_accum_beta_pkg: state enum (IDLE, ACCUM, HOLD) and the default
//    DATA_W/ACC_W/COUNT constants shared with the adder-side wrapper.
//  - Single flat module. The output register slice is inline; no sub-module is warranted.
// TESTING
//  1. Reset: hold reset 3 cycles with in_valid=1 -> out_valid=0, out_sum=0, in_ready=1
//     after release.
//  2. COUNT=4, out_ready=1, back-to-back in_data 1,2,3,4 ->
//     out_sum=10, out_count=4, out_ovf=0, one cycle after the 4th accept.
//  3. ACC_W=DATA_W=32, COUNT=2, in_data 0xFFFF_FFFF, 0x2 ->
//     out_sum=0x1, out_ovf=1.
//  4. in_data 5,7 then flush=1 with in_valid=0 -> out_sum=12, out_count=2;
//     a second flush in IDLE produces no output.
//  5. out_ready=0 for 5 cycles while a result is held ->
//     in_ready=0, out_* stable; release with in_valid=1, in_data=9 ->
//     result taken and a new batch starts at acc=9, cnt=1.
//  6. Assert reset while cnt=3 and again while out_valid=1 ->
//     next batch starts from zero; no stale out_valid.

Source files
------------

// File: rtl/sum_accum_beta_pkg.sv
// Shared definitions for the sum accumulator: FSM state encoding and the
// default widths/batch size used by the adder-side wrapper.
package sum_accum_beta_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ACC_W  = 40;
    localparam int DEF_COUNT  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/sum_accum_beta.sv
// Batch accumulator for the adder result stream: sums COUNT samples (or fewer
// on flush) and holds total, sample count and wrap flag until the sink takes it.
module sum_accum_beta
    import sum_accum_beta_pkg::*;
#(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  ACC_W  = DEF_ACC_W,
    parameter int  COUNT  = DEF_COUNT,
    localparam int CNT_W  = $clog2(COUNT + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    state_t           state_q;
    state_t           state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] acc_n;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_n;
    logic             ovf_q;
    logic             ovf_base;
    logic             ovf_n;
    logic [ACC_W:0]   data_ext;
    logic [ACC_W:0]   sum_ext;
    logic             in_fire;
    logic             out_fire;
    logic             close;

    assign out_valid = (state_q == HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // A sample accepted while a result is held always opens a fresh batch.
    always_comb begin
        data_ext             = '0;
        data_ext[DATA_W-1:0] = in_data;
        acc_base             = out_valid ? '0 : acc_q;
        cnt_base             = out_valid ? '0 : cnt_q;
        ovf_base             = out_valid ? 1'b0 : ovf_q;
        sum_ext              = {1'b0, acc_base} + data_ext;
        acc_n                = acc_base;
        cnt_n                = cnt_base;
        ovf_n                = ovf_base;
        if (in_fire) begin
            acc_n = sum_ext[ACC_W-1:0];
            cnt_n = cnt_base + CNT_W'(1);
            ovf_n = ovf_base | sum_ext[ACC_W];
        end
        close = (cnt_n == CNT_W'(COUNT)) || (flush && (cnt_n != '0));
    end

    always_comb begin
        state_d = state_q;
        if (close) begin
            state_d = HOLD;
        end else if (out_valid && !out_fire) begin
            state_d = HOLD;
        end else if (cnt_n != '0) begin
            state_d = ACCUM;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Closing a batch moves the running totals into the output slice.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (close) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_sum   <= acc_n;
            out_count <= cnt_n;
            out_ovf   <= ovf_n;
        end else begin
            acc_q     <= acc_n;
            cnt_q     <= cnt_n;
            ovf_q     <= ovf_n;
        end
    end

endmodule
